seq_slice_comparator: RTL and testbench
=======================================

Name: seq_slice_comparator

Overview:
- Multi-cycle magnitude and equality comparator for two WIDTH-bit operands.
- Successor to the fixed 32-bit combinational equality compare: parametrised width, eq/gt/lt outputs, and a signed/unsigned mode chosen per transaction.
- Compares one SLICE-bit slice per clock, MSB slice first, behind valid/ready handshakes.
- Sits between operand producers and control logic where a full-width compare would miss timing.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of SLICE.
SLICE, 8, bits compared per cycle; NS = WIDTH/SLICE, NS >= 1.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operands and mode valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
mode_signed  input  1  1 = two's-complement compare; 0 = unsigned compare.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
eq  output  1  A == B.
gt  output  1  A > B.
lt  output  1  A < B.

Behaviour:
- Interface is fixed: one clock (clk); reset rst is asynchronous and active-high.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - CMP: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- in_ready is decoded directly from the state (state==IDLE).
- Reset: state returns to IDLE asynchronously.
  - Register values on reset: eq=0, gt=0, lt=0, out_valid=0, slice index=0, operand regs=0.
  - in_ready reads 1 while in reset.
  - Any in-flight transaction is discarded; no result is produced for it.
- IDLE:
  - Accept on in_valid && in_ready.
  - Capture a, b, mode_signed; set idx = NS-1; clear the decided flag; go to CMP.
- CMP: at each edge, compare slice idx, bits [idx*SLICE +: SLICE].
  - Slice NS-1 is compared signed when mode_signed=1, i.e. MSB inverted, then unsigned compare. All other slices are compared unsigned.
  - If the slices differ and decided=0: latch gt/lt from this slice and set decided=1.
  - Early exit: leave when the slices differ or idx==0.
  - On exit go to DONE with out_valid=1. If no slice differed, eq=1, gt=0, lt=0.
  - Otherwise idx decrements.
- Latency from the accept edge to out_valid high:
  - j cycles, where j is the 1-based position of the first differing slice counted from the MSB.
  - NS cycles when A == B.
- DONE:
  - eq/gt/lt held stable while out_valid=1.
  - On out_ready=1: go to IDLE and clear out_valid. eq/gt/lt keep their values.
  - While in DONE, in_valid is ignored; no accept happens.
- Invariant: exactly one of eq/gt/lt is 1 whenever out_valid=1.
- Throughput: at most one transaction per (latency + 2) cycles; there is no overlap of accept and output.
- NS=1: CMP always lasts 1 cycle; the single slice uses the signed rule when mode_signed=1.
- The slice index register width is max(1, clog2(NS)).

Optional Feature:
SEQ_CMP_EARLY_EXIT_EN
- Defined: early exit as described above; latency varies between 1 and NS cycles.
- Not defined: constant latency. CMP always runs all NS slices down to idx==0. The result comes from the first differing slice, held by the decided flag; later slices do not overwrite it. out_valid always rises NS cycles after accept.
- eq/gt/lt values are identical in both builds.

Test Plan:
All scenarios use WIDTH=32, SLICE=8 (NS=4).
1. a=b=0x12345678, mode_signed=0, out_ready=1 -> eq=1, gt=0, lt=0; out_valid 4 cycles after accept in both builds.
2. a=0x80000000, b=0x7FFFFFFF, mode_signed=0 -> gt=1. out_valid 1 cycle after accept with SEQ_CMP_EARLY_EXIT_EN; 4 cycles without it.
3. Same operands as scenario 2 with mode_signed=1 -> lt=1, eq=0, gt=0.
4. a=0x000000FF, b=0x000000FE, mode_signed=1 -> gt=1, out_valid after 4 cycles. Also a=0x01000000, b=0x01FFFFFF without the macro -> lt=1 after 4 cycles; later slices must not override the result.
5. Backpressure: result of scenario 1 with out_ready=0 for 3 cycles while in_valid=1 with new operands.
   - out_valid and eq must stay stable; in_ready=0; no accept.
   - out_ready=1 -> IDLE next cycle, in_ready=1, new operands accepted.
6. Assert rst mid-CMP (2 cycles after accepting a=1, b=2) -> immediate IDLE, out_valid=0, eq/gt/lt=0, in_ready=1. After release, a=5, b=5 completes with eq=1.

Source files
------------

// File: rtl/seq_slice_comparator_if.sv
// seq_slice_comparator_if: operand/result handshake bundle for seq_slice_comparator.
interface seq_slice_comparator_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode_signed;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             lt;
  modport master (
    output in_valid, a, b, mode_signed, out_ready,
    input  in_ready, out_valid, eq, gt, lt
  );
  modport slave (
    input  in_valid, a, b, mode_signed, out_ready,
    output in_ready, out_valid, eq, gt, lt
  );
endinterface

// File: rtl/seq_slice_comparator.sv
// seq_slice_comparator: multi-cycle eq/gt/lt compare, one SLICE-bit slice per clock, MSB slice first.
// Define SEQ_CMP_EARLY_EXIT_EN to stop at the first differing slice; otherwise latency is always NS.
module seq_slice_comparator #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic clk,
  input logic rst,
  seq_slice_comparator_if.slave bus
);
  localparam int NS = WIDTH / SLICE;
  localparam int IW = NS > 1 ? $clog2(NS) : 1;
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic [IW-1:0]    idx;
  logic             decided;
  logic             eq_q, gt_q, lt_q;
  logic [SLICE-1:0] msk, sa, sb;
  logic             diff, last, exit_cmp, accept;
  // Top slice in signed mode: flipping its MSB turns two's-complement order into unsigned order.
  always_comb begin
    msk      = (mode_q && idx == IW'(NS - 1)) ? (SLICE'(1) << (SLICE - 1)) : '0;
    sa       = SLICE'(a_q >> (SLICE * int'(idx))) ^ msk;
    sb       = SLICE'(b_q >> (SLICE * int'(idx))) ^ msk;
    diff     = sa != sb;
    last     = idx == '0;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    exit_cmp = diff || last;
`else
    exit_cmp = last;
`endif
    accept   = state == IDLE && bus.in_valid;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = accept                            ? CMP  :
              (state == CMP && exit_cmp)        ? DONE :
              (state == DONE && bus.out_ready)  ? IDLE : state;
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == DONE;
    bus.eq        = eq_q;
    bus.gt        = gt_q;
    bus.lt        = lt_q;
  end
  // decided pins the result to the first differing slice when later slices are still scanned.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      idx     <= '0;
      decided <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      mode_q  <= bus.mode_signed;
      idx     <= IW'(NS - 1);
      decided <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else if (state == CMP) begin
      if (diff && !decided) begin
        decided <= 1'b1;
        gt_q    <= sa > sb;
        lt_q    <= sa < sb;
      end
      if (exit_cmp && !decided && !diff) eq_q <= 1'b1;
      if (!exit_cmp) idx <= idx - 1'b1;
    end
endmodule

// File: tb/tb_seq_slice_comparator.sv
// tb_seq_slice_comparator: randomized and directed checks of seq_slice_comparator against a behavioural model.
module tb_seq_slice_comparator;
  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int NS = WIDTH / SLICE;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int errs = 0;
  always #5 clk = ~clk;
  seq_slice_comparator_if #(.WIDTH(WIDTH)) bus();
  seq_slice_comparator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (a == b) return 3'b100;
    if (s ? ($signed(a) > $signed(b)) : (a > b)) return 3'b010;
    return 3'b001;
  endfunction
  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    for (int j = 1; j <= NS; j++)
      if (((a ^ b) >> (WIDTH - j * SLICE)) != 0) return j;
`endif
    return NS;
  endfunction
  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errs++; $display("FAIL wait_ready: in_ready=%b want 1 within 20 cycles", bus.in_ready);
    end
  endtask
  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic m);
    bus.a = a; bus.b = b; bus.mode_signed = m; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask
  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.mode_signed = 1'b0;
    #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt} !== 5'b10000) begin
      errs++; $display("FAIL reset_async: rdy/vld/eq/gt/lt=%b want 10000", {bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errs++; $display("FAIL reset_release: rdy/vld=%b want 10", {bus.in_ready, bus.out_valid});
    end
  endtask
  task automatic test_directed();
    logic [31:0] ta [6] = '{32'h12345678, 32'h80000000, 32'h80000000, 32'h000000FF, 32'h01000000, 32'h01000000};
    logic [31:0] tb [6] = '{32'h12345678, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h000000FE, 32'h01FFFFFF, 32'h01FFFFFF};
    logic        tm [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0]  te [6] = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b001, 3'b001};
    int          tl [6];
    int lat;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    tl = '{4, 1, 1, 4, 2, 2};
`else
    tl = '{4, 4, 4, 4, 4, 4};
`endif
    for (int i = 0; i < 6; i++) begin
      wait_ready();
      start(ta[i], tb[i], tm[i]);
      wait_result(lat);
      vectors++;
      if (lat !== tl[i]) begin
        errs++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tl[i]);
      end
      vectors++;
      if ({bus.eq, bus.gt, bus.lt} !== te[i]) begin
        errs++; $display("FAIL dir%0d_result: eq/gt/lt=%b want %b", i, {bus.eq, bus.gt, bus.lt}, te[i]);
      end
      consume();
      vectors++;
      if ({bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt} !== {2'b10, te[i]}) begin
        errs++; $display("FAIL dir%0d_release: rdy/vld/eq/gt/lt=%b want %b", i, {bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt}, {2'b10, te[i]});
      end
    end
  endtask
  task automatic test_backpressure();
    int lat;
    wait_ready();
    start(32'h12345678, 32'h12345678, 1'b0);
    wait_result(lat);
    vectors++;
    if (lat !== 4 || {bus.eq, bus.gt, bus.lt} !== 3'b100) begin
      errs++; $display("FAIL bp_first: lat=%0d eq/gt/lt=%b want 4 100", lat, {bus.eq, bus.gt, bus.lt});
    end
    bus.a = 32'hA; bus.b = 32'hB; bus.mode_signed = 1'b0; bus.in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.eq, bus.gt, bus.lt} !== 5'b10100) begin
        errs++; $display("FAIL bp_hold: vld/rdy/eq/gt/lt=%b want 10100", {bus.out_valid, bus.in_ready, bus.eq, bus.gt, bus.lt});
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errs++; $display("FAIL bp_idle: rdy/vld=%b want 10", {bus.in_ready, bus.out_valid});
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      errs++; $display("FAIL bp_accept: in_ready=%b want 0", bus.in_ready);
    end
    wait_result(lat);
    vectors++;
    if (lat !== model_lat(32'hA, 32'hB) || {bus.eq, bus.gt, bus.lt} !== model(32'hA, 32'hB, 1'b0)) begin
      errs++; $display("FAIL bp_second: lat=%0d eq/gt/lt=%b want %0d %b", lat, {bus.eq, bus.gt, bus.lt}, model_lat(32'hA, 32'hB), model(32'hA, 32'hB, 1'b0));
    end
    consume();
  endtask
  task automatic test_reset_midflight();
    int lat;
    wait_ready();
    start(32'd1, 32'd2, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt} !== 5'b10000) begin
      errs++; $display("FAIL midrst_state: rdy/vld/eq/gt/lt=%b want 10000", {bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      errs++; $display("FAIL midrst_discard: out_valid=%b want 0", bus.out_valid);
    end
    wait_ready();
    start(32'd5, 32'd5, 1'b0);
    wait_result(lat);
    vectors++;
    if (lat !== 4 || {bus.eq, bus.gt, bus.lt} !== 3'b100) begin
      errs++; $display("FAIL midrst_after: lat=%0d eq/gt/lt=%b want 4 100", lat, {bus.eq, bus.gt, bus.lt});
    end
    consume();
  endtask
  task automatic test_random();
    logic [31:0] a, b;
    logic        m;
    int          lat, k;
    for (int i = 0; i < 300; i++) begin
      a = $urandom; m = 1'($urandom_range(0, 1)); k = $urandom_range(0, 3);
      b = k == 0 ? a :
          k == 1 ? 32'($urandom) :
          k == 2 ? a ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3))) :
                   ($urandom_range(0, 1) ? 32'h80000000 : 32'h7FFFFFFF);
      wait_ready();
      start(a, b, m);
      wait_result(lat);
      vectors++;
      if (lat !== model_lat(a, b) || {bus.eq, bus.gt, bus.lt} !== model(a, b, m)) begin
        errs++; $display("FAIL rand%0d a=%h b=%h s=%b: lat=%0d eq/gt/lt=%b want %0d %b", i, a, b, m, lat, {bus.eq, bus.gt, bus.lt}, model_lat(a, b), model(a, b, m));
      end
      if (bus.out_valid) begin
        vectors++;
        if ($countones({bus.eq, bus.gt, bus.lt}) != 1) begin
          errs++; $display("FAIL rand%0d_onehot: eq/gt/lt=%b want exactly one set", i, {bus.eq, bus.gt, bus.lt});
        end
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
      consume();
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
